// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the SRAM-like two-into-one arbiter: source IDs, the
// request bundle that gets muxed onto the memory port, and counter helpers.
package sram_like_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned STRB_W = 4;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

  function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned limit);
    return (cnt >= limit) ? limit : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/sram_src_fifo.sv
// In-order 1-bit source-ID FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate counter.
module sram_src_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_r;
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign empty     = (wptr_r == rptr_r);
  assign dout      = mem_r[rptr_r[AW-1:0]];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage and pointer update; a pop while full frees its slot only next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_r  <= '0;
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r[AW-1:0]] <= din;
        wptr_r                <= wptr_r + (AW+1)'(1);
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the instruction and data SRAM-like ports onto one memory port and
// steers each data_ok/rdata back to the source of the oldest outstanding access.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [SIZE_W-1:0] inst_sram_size,
  input  logic [STRB_W-1:0] inst_sram_wstrb,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [SIZE_W-1:0] data_sram_size,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  src_e                grant_s;
  src_e                lock_src_r;
  src_e                head_src_s;
  logic                lock_valid_r;
  logic [STARVE_W-1:0] starve_cnt_r;
  sram_req_t           inst_req_s;
  sram_req_t           data_req_s;
  sram_req_t           sel_req_s;
  logic                sel_valid_s;
  logic                accept_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                fifo_dout_s;

  assign inst_req_s = '{wr: inst_sram_wr, size: inst_sram_size, wstrb: inst_sram_wstrb,
                        addr: inst_sram_addr, wdata: inst_sram_wdata};
  assign data_req_s = '{wr: data_sram_wr, size: data_sram_size, wstrb: data_sram_wstrb,
                        addr: data_sram_addr, wdata: data_sram_wdata};

  // Grant: a pending lock wins, then a starved inst request, then data over inst.
  always_comb begin
    grant_s = SRC_INST;
    if (lock_valid_r) begin
      grant_s = lock_src_r;
    end else if ((starve_cnt_r == STARVE_W'(STARVE_LIMIT)) && inst_sram_req) begin
      grant_s = SRC_INST;
    end else if (data_sram_req) begin
      grant_s = SRC_DATA;
    end else begin
      grant_s = SRC_INST;
    end
  end

  // Route the granted requester onto the memory side.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_req_s   = '0;
    case (grant_s)
      SRC_INST: begin
        sel_valid_s = inst_sram_req;
        sel_req_s   = inst_req_s;
      end
      SRC_DATA: begin
        sel_valid_s = data_sram_req;
        sel_req_s   = data_req_s;
      end
      default: begin
        sel_valid_s = 1'b0;
        sel_req_s   = '0;
      end
    endcase
  end

  assign mem_req   = sel_valid_s & ~fifo_full_s & ~reset;
  assign mem_wr    = sel_req_s.wr;
  assign mem_size  = sel_req_s.size;
  assign mem_wstrb = sel_req_s.wstrb;
  assign mem_addr  = sel_req_s.addr;
  assign mem_wdata = sel_req_s.wdata;

  assign accept_s          = mem_req & mem_addr_ok;
  assign inst_sram_addr_ok = accept_s & (grant_s == SRC_INST);
  assign data_sram_addr_ok = accept_s & (grant_s == SRC_DATA);

  // A data_ok with nothing outstanding is dropped here rather than misrouted.
  assign pop_s             = mem_data_ok & ~fifo_empty_s & ~reset;
  assign head_src_s        = src_e'(fifo_dout_s);
  assign inst_sram_data_ok = pop_s & (head_src_s == SRC_INST);
  assign data_sram_data_ok = pop_s & (head_src_s == SRC_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  sram_src_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept_s),
    .din   (grant_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Grant lock and starvation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_r <= 1'b0;
      lock_src_r   <= SRC_INST;
      starve_cnt_r <= '0;
    end else begin
      lock_valid_r <= mem_req & ~mem_addr_ok;
      lock_src_r   <= grant_s;
      if (accept_s) begin
        if ((grant_s == SRC_DATA) && inst_sram_req) begin
          starve_cnt_r <= STARVE_W'(sat_inc(32'(starve_cnt_r), STARVE_LIMIT));
        end else begin
          starve_cnt_r <= '0;
        end
      end
    end
  end

endmodule
